fetch_stall_ctrl: RTL

Consumes the stall/flush requests produced by hazard detection and applies them to the front end of the 5-stage datapath. Owns the PC register and the IF/ID pipeline register, and drives the bubble-insert control into the ID/EX register. Also handles taken-branch redirect, counts stall cycles for performance debug, and flags a runaway stall.

---
 rtl/fetch_stall_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/fetch_stall_ctrl.sv
// Front-end pipeline control for the 5-stage datapath.
// Owns the PC and the IF/ID register. Applies hazard stalls, flushes and
// taken-branch redirects, and drives the ID/EX bubble request. It also keeps
// a saturating stall-cycle counter and a sticky runaway-stall flag.
module fetch_stall_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             FlushIF,
  input  logic             FlushID,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic [31:0]      Instruction_IF,
  output logic [31:0]      PC_IF,
  output logic [31:0]      Instruction_ID,
  output logic [31:0]      PCPlus4_ID,
  output logic             Valid_ID,
  output logic             Bubble_EX,
  output logic [CNT_W-1:0] StallCount,
  output logic             StallTimeout
);

  // Nine bits holds MAX_STALL+1 for every legal MAX_STALL (up to 255), so the
  // run-length counter can always step past the limit before it saturates.
  localparam int CONSEC_W = 9;

  logic                stall_eff;
  logic [31:0]         pc_plus4;
  logic [31:0]         redirect_pc;
  logic [CONSEC_W-1:0] consec_cnt;
  logic [CONSEC_W-1:0] consec_next;
  logic                unused_target_bits;

  // A branch wins over a stall, so a stall only counts while no branch is active
  assign stall_eff   = Stall & ~BranchTaken;
  assign pc_plus4    = PC_IF + 32'd4;
  assign redirect_pc = {BranchTarget[31:2], 2'b00};

  // Branch targets are forced to word alignment, so the low bits are dropped
  assign unused_target_bits = ^BranchTarget[1:0];

  // The ID/EX bubble has to take effect in the same cycle as the request
  assign Bubble_EX = Reset | FlushID | BranchTaken | stall_eff;

  // Next run length, saturated so a very long stall cannot wrap back under the limit
  always_comb begin
    consec_next = consec_cnt;
    if (consec_cnt != '1) begin
      consec_next = consec_cnt + CONSEC_W'(1);
    end
  end

  // PC and IF/ID update, priority redirect > stall > IF flush > sequential fetch
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC_IF          <= RESET_PC;
      Instruction_ID <= NOP_INSTR;
      PCPlus4_ID     <= 32'd0;
      Valid_ID       <= 1'b0;
    end else if (BranchTaken) begin
      PC_IF          <= redirect_pc;
      Instruction_ID <= NOP_INSTR;
      PCPlus4_ID     <= 32'd0;
      Valid_ID       <= 1'b0;
    end else if (Stall) begin
      PC_IF          <= PC_IF;
      Instruction_ID <= Instruction_ID;
      PCPlus4_ID     <= PCPlus4_ID;
      Valid_ID       <= Valid_ID;
    end else if (FlushIF) begin
      PC_IF          <= pc_plus4;
      Instruction_ID <= NOP_INSTR;
      PCPlus4_ID     <= 32'd0;
      Valid_ID       <= 1'b0;
    end else begin
      PC_IF          <= pc_plus4;
      Instruction_ID <= Instruction_IF;
      PCPlus4_ID     <= pc_plus4;
      Valid_ID       <= 1'b1;
    end
  end

  // Stall statistics: saturating total, run length, and the sticky timeout flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCount   <= '0;
      consec_cnt   <= '0;
      StallTimeout <= 1'b0;
    end else if (stall_eff) begin
      if (StallCount != '1) begin
        StallCount <= StallCount + CNT_W'(1);
      end
      consec_cnt <= consec_next;
      if (32'(consec_next) > MAX_STALL) begin
        StallTimeout <= 1'b1;
      end
    end else begin
      consec_cnt <= '0;
    end
  end

endmodule
